mem_access_stage: RTL and testbench

- MEM stage of the pipelined core, between the EX/MEM pipe register and the MEM/WB pipe register.
- Converts load/store requests into a req/ack handshake toward data memory.
- Stalls the pipeline until the access completes.
- Presents ReadData_o and AluResult_o to the MEM/WB register, which captures them with no extra logic.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_access_stage_timeout.sv | 33 +++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
// Holds the stage FSM encoding, the default ack timeout and the word-alignment mask.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam int         TIMEOUT_DEFAULT = 16;
    localparam logic [1:0] ALIGN_MASK      = 2'b11;

endpackage

// File: rtl/mem_access_stage_timeout.sv
// mem_timeout_counter: counts ACCESS cycles without ack and flags expiry.
// Ports: CLK, RST (async, active-high), i_clear (entering ACCESS),
//   i_run (in ACCESS), i_ack (mem_ack_i), o_expired (last allowed cycle, no ack).
import mem_stage_pkg::*;

module mem_timeout_counter #(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expired
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] r_cnt;

    assign o_expired = i_run & ~i_ack & (r_cnt == W'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run & ~i_ack & ~o_expired) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage turning load/store into a req/ack memory access,
// stalling the pipeline until it completes.
// Ports: CLK, RST (async, active-high); EX/MEM side Valid_i, AluResult_i,
//   WriteData_i, MemWE_i, MemRE_i; MEM/WB side AluResult_o, ReadData_o;
//   pipeline control Stall_o, MisAlign_o; memory side mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o, mem_rdata_i, mem_ack_i.
// Macro MEM_TIMEOUT_EN adds the ack timeout and the sticky TimeoutErr_o port.
import mem_stage_pkg::*;

module mem_access_stage #(
    parameter int N       = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Valid_i,
    input  logic [N-1:0] AluResult_i,
    input  logic [N-1:0] WriteData_i,
    input  logic         MemWE_i,
    input  logic         MemRE_i,
    output logic [N-1:0] AluResult_o,
    output logic [N-1:0] ReadData_o,
    output logic         Stall_o,
    output logic         MisAlign_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [N-1:0] mem_addr_o,
    output logic [N-1:0] mem_wdata_o,
    input  logic [N-1:0] mem_rdata_i,
    input  logic         mem_ack_i
`ifdef MEM_TIMEOUT_EN
    ,
    output logic         TimeoutErr_o
`endif
);

    mem_state_t   r_state;
    mem_state_t   w_next;
    logic         r_we;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_rdata;
    logic         w_mem_op;
    logic         w_mis;
    logic         w_access;
    logic         w_start;
    logic         w_in_access;
    logic         w_expired;

    assign w_mem_op    = Valid_i & (MemWE_i | MemRE_i);
    assign w_mis       = w_mem_op & ((AluResult_i[1:0] & ALIGN_MASK) != 2'b00);
    assign w_access    = w_mem_op & ~w_mis;
    assign w_start     = (r_state == IDLE) & w_access;
    assign w_in_access = (r_state == ACCESS);

`ifdef MEM_TIMEOUT_EN
    logic r_terr;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (w_start),
        .i_run     (w_in_access),
        .i_ack     (mem_ack_i),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_terr <= 1'b0;
        end else if (w_expired) begin
            r_terr <= 1'b1;
        end
    end

    assign TimeoutErr_o = r_terr;
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack_i || w_expired) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request fields are captured once on entry and held until the ack,
    // so EX/MEM input changes during the stall have no effect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= {AluResult_i[N-1:2], 2'b00};
                r_wdata <= WriteData_i;
                r_we    <= MemWE_i;
            end
            if (w_in_access) begin
                if (mem_ack_i) begin
                    if (!r_we) begin
                        r_rdata <= mem_rdata_i;
                    end
                end else if (w_expired) begin
                    r_rdata <= '0;
                end
            end
        end
    end

    // Stall is gated by RST so the pipeline is released the moment reset hits,
    // even while EX/MEM still presents the abandoned access.
    assign Stall_o     = ~RST & (w_start | w_in_access);
    assign mem_req_o   = w_in_access;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign ReadData_o  = r_rdata;
    assign AluResult_o = AluResult_i;
    assign MisAlign_o  = w_mis;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized transaction-level bench for mem_access_stage.
// Expected outputs come from a per-instruction model of stall/request timing.
module tb_mem_access_stage;

    localparam int N  = 32;
    localparam int TO = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Valid_i;
    logic [N-1:0] AluResult_i;
    logic [N-1:0] WriteData_i;
    logic         MemWE_i;
    logic         MemRE_i;
    logic [N-1:0] AluResult_o;
    logic [N-1:0] ReadData_o;
    logic         Stall_o;
    logic         MisAlign_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [N-1:0] mem_addr_o;
    logic [N-1:0] mem_wdata_o;
    logic [N-1:0] mem_rdata_i;
    logic         mem_ack_i;
`ifdef MEM_TIMEOUT_EN
    logic         TimeoutErr_o;
`endif

    mem_access_stage #(.N(N), .TIMEOUT(TO)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Valid_i     (Valid_i),
        .AluResult_i (AluResult_i),
        .WriteData_i (WriteData_i),
        .MemWE_i     (MemWE_i),
        .MemRE_i     (MemRE_i),
        .AluResult_o (AluResult_o),
        .ReadData_o  (ReadData_o),
        .Stall_o     (Stall_o),
        .MisAlign_o  (MisAlign_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef MEM_TIMEOUT_EN
        ,
        .TimeoutErr_o (TimeoutErr_o)
`endif
    );

    always #5 CLK = ~CLK;

    int npass = 0;
    int ntot  = 0;
    int stall_seen = 0;
    logic chk_en = 1'b0;

    // model state
    logic         e_stall = 1'b0;
    logic         e_req   = 1'b0;
    logic         e_mis   = 1'b0;
    logic         m_we    = 1'b0;
    logic [N-1:0] m_addr  = '0;
    logic [N-1:0] m_wdata = '0;
    logic [N-1:0] m_rdata = '0;
    logic         m_terr  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("stall", 32'(Stall_o), 32'(e_stall));
            check("req", 32'(mem_req_o), 32'(e_req));
            check("misalign", 32'(MisAlign_o), 32'(e_mis));
            check("alu_pass", AluResult_o, AluResult_i);
            check("we", 32'(mem_we_o), 32'(m_we));
            check("addr", mem_addr_o, m_addr);
            check("wdata", mem_wdata_o, m_wdata);
            check("rdata", ReadData_o, m_rdata);
`ifdef MEM_TIMEOUT_EN
            check("terr", 32'(TimeoutErr_o), 32'(m_terr));
`endif
            if (Stall_o) stall_seen++;
        end
    end

    function automatic logic mis_of(input logic v, we, re,
                                    input logic [N-1:0] a);
        return v & (we | re) & (a[1:0] != 2'b00);
    endfunction

    // One instruction through MEM: dly = ACCESS cycles before ack,
    // to = never ack (timeout build only).
    task automatic run_instr(input logic v, we, re,
                             input logic [N-1:0] a, wd, rd,
                             input int dly, input bit to);
        logic mis, acc;
        int nacc;
        mis = mis_of(v, we, re, a);
        acc = v & (we | re) & ~mis;
        stall_seen = 0;
        @(posedge CLK); #1;
        Valid_i = v; MemWE_i = we; MemRE_i = re;
        AluResult_i = a; WriteData_i = wd;
        mem_ack_i = 1'($urandom % 2);
        mem_rdata_i = $urandom;
        e_stall = acc; e_req = 1'b0; e_mis = mis;
        if (!acc) return;
        nacc = to ? TO : dly + 1;
        for (int k = 0; k < nacc; k++) begin
            @(posedge CLK); #1;
            if (k == 0) begin
                m_addr = {a[N-1:2], 2'b00};
                m_wdata = wd;
                m_we = we;
            end
            Valid_i = 1'($urandom % 2);
            MemRE_i = 1'($urandom % 2);
            mem_ack_i = !to && (k == dly);
            mem_rdata_i = (!to && k == dly) ? rd : $urandom;
            e_stall = 1'b1; e_req = 1'b1;
            e_mis = mis_of(Valid_i, MemWE_i, MemRE_i, AluResult_i);
        end
        @(posedge CLK); #1;
        if (to) begin
            m_rdata = '0;
            m_terr = 1'b1;
        end else if (!we) begin
            m_rdata = rd;
        end
        Valid_i = v; MemRE_i = re;
        mem_ack_i = 1'($urandom % 2);
        mem_rdata_i = $urandom;
        e_stall = 1'b0; e_req = 1'b0; e_mis = mis;
    endtask

    initial begin
        RST = 1'b1;
        Valid_i = 0; MemWE_i = 0; MemRE_i = 0;
        AluResult_i = '0; WriteData_i = '0;
        mem_rdata_i = '0; mem_ack_i = 0;
        #1;
        check("rst_stall", 32'(Stall_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_rdata", ReadData_o, 32'd0);
        #12 RST = 1'b0;
        chk_en = 1'b1;

        // load, ack in first ACCESS cycle
        run_instr(1, 0, 1, 32'h10, 32'h0, 32'h7894ACD0, 0, 0);
        @(negedge CLK); #1;
        check("t1_stall_cyc", 32'(stall_seen), 32'd2);
        check("t1_rdata", ReadData_o, 32'h7894ACD0);
        check("t1_addr", mem_addr_o, 32'h10);
        check("t1_we", 32'(mem_we_o), 32'd0);

        // store, ack after 3 wait cycles
        run_instr(1, 1, 0, 32'h20, 32'hDEADBEEF, 32'h0, 3, 0);
        @(negedge CLK); #1;
        check("t2_stall_cyc", 32'(stall_seen), 32'd5);
        check("t2_wdata", mem_wdata_o, 32'hDEADBEEF);
        check("t2_we", 32'(mem_we_o), 32'd1);
        check("t2_rdata", ReadData_o, 32'h7894ACD0);

        // ALU-only
        run_instr(1, 0, 0, 32'h2, 32'h0, 32'h0, 0, 0);
        @(negedge CLK); #1;
        check("t3_stall", 32'(Stall_o), 32'd0);
        check("t3_req", 32'(mem_req_o), 32'd0);
        check("t3_alu", AluResult_o, 32'h2);

        // misaligned load
        run_instr(1, 0, 1, 32'h13, 32'h0, 32'h0, 0, 0);
        @(negedge CLK); #1;
        check("t4_mis", 32'(MisAlign_o), 32'd1);
        check("t4_req", 32'(mem_req_o), 32'd0);
        check("t4_stall", 32'(Stall_o), 32'd0);

        // reset in the middle of ACCESS
        @(posedge CLK); #1;
        Valid_i = 1; MemWE_i = 0; MemRE_i = 1;
        AluResult_i = 32'h40; mem_ack_i = 0;
        e_stall = 1; e_req = 0; e_mis = 0;
        @(posedge CLK); #1;
        m_addr = 32'h40; m_we = 0;
        e_req = 1;
        chk_en = 1'b0;
        RST = 1'b1;
        Valid_i = 0; MemRE_i = 0;
        #1;
        check("t5_req", 32'(mem_req_o), 32'd0);
        check("t5_stall", 32'(Stall_o), 32'd0);
        check("t5_addr", mem_addr_o, 32'd0);
        #2 RST = 1'b0;
        m_addr = '0; m_wdata = '0; m_we = 0; m_rdata = '0; m_terr = 0;
        e_stall = 0; e_req = 0;
        @(posedge CLK); #1;
        mem_ack_i = 1; mem_rdata_i = 32'h5555AAAA;
        @(negedge CLK); #1;
        check("t5_ack_ign", ReadData_o, 32'd0);
        check("t5_req2", 32'(mem_req_o), 32'd0);
        chk_en = 1'b1;
        run_instr(1, 0, 1, 32'h44, 32'h0, 32'h12345678, 1, 0);
        @(negedge CLK); #1;
        check("t5_reload", ReadData_o, 32'h12345678);

`ifdef MEM_TIMEOUT_EN
        run_instr(1, 0, 1, 32'h80, 32'h0, 32'h0, 0, 1);
        @(negedge CLK); #1;
        check("t6_stall_cyc", 32'(stall_seen), 32'd17);
        check("t6_rdata", ReadData_o, 32'd0);
        check("t6_terr", 32'(TimeoutErr_o), 32'd1);
`endif

        for (int i = 0; i < 200; i++) begin
            int kind;
            logic [N-1:0] a;
            kind = int'($urandom_range(0, 5));
            a = $urandom;
            if (kind != 5) a[1:0] = 2'b00;
            unique case (kind)
                0: run_instr(0, 1'($urandom % 2), 1'($urandom % 2),
                             a, $urandom, $urandom, 0, 0);
                1: run_instr(1, 0, 0, a, $urandom, $urandom, 0, 0);
                2: run_instr(1, 0, 1, a, $urandom, $urandom,
                             int'($urandom_range(0, 5)), 0);
                3: run_instr(1, 1, 0, a, $urandom, $urandom,
                             int'($urandom_range(0, 5)), 0);
                4: run_instr(1, 1, 1, a, $urandom, $urandom,
                             int'($urandom_range(0, 5)), 0);
                default: run_instr(1, 1'($urandom % 2), 1,
                                   a, $urandom, $urandom, 0, 0);
            endcase
        end
        @(negedge CLK); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
